// File: rtl/mux_scan_sequencer.sv
// Sweeps the 6:1 mux select, samples each channel after a settle dwell.
// MUX_SCAN_CONTINUOUS_EN: back-to-back sweeps while start stays high.
module mux_scan_sequencer #(
   parameter int NUM_CH = 6,
   parameter int SEL_W  = 3,
   parameter int DWELL  = 4
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              start,
   output logic [SEL_W-1:0]  sel,
   input  logic              mux_in,
   output logic              busy,
   output logic              done,
   output logic [NUM_CH-1:0] captured,
   output logic [SEL_W:0]    ones_count
);

   localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [DW_W-1:0]  DW_LAST = DW_W'(DWELL - 1);
   localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(NUM_CH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;

   state_t            r_state;
   logic [SEL_W-1:0]  r_ch;
   logic [DW_W-1:0]   r_dwell;
   logic [NUM_CH-1:0] r_shadow;
   logic [NUM_CH-1:0] w_shadow_nxt;
   logic [SEL_W:0]    w_pop;

   // Shadow with the current channel's bit already merged, so the
   // final sample lands in captured on the same edge it is taken.
   always_comb begin
      w_shadow_nxt = r_shadow;
      for (int k = 0; k < NUM_CH; k++) begin
         if (r_ch == SEL_W'(k)) begin
            w_shadow_nxt[k] = mux_in;
         end
      end
      w_pop = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         w_pop = w_pop + (SEL_W+1)'(w_shadow_nxt[k]);
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state    <= S_IDLE;
         r_ch       <= '0;
         r_dwell    <= '0;
         r_shadow   <= '0;
         sel        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         captured   <= '0;
         ones_count <= '0;
      end else begin
         done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               sel  <= '0;
               busy <= 1'b0;
               if (start) begin
                  r_state  <= S_SETTLE;
                  r_ch     <= '0;
                  r_dwell  <= '0;
                  r_shadow <= '0;
                  busy     <= 1'b1;
               end
            end
            S_SETTLE: begin
               if (r_dwell == DW_LAST) begin
                  r_state <= S_SAMPLE;
               end else begin
                  r_dwell <= r_dwell + 1'b1;
               end
            end
            S_SAMPLE: begin
               r_shadow <= w_shadow_nxt;
               if (r_ch == CH_LAST) begin
                  r_state    <= S_DONE;
                  captured   <= w_shadow_nxt;
                  ones_count <= w_pop;
                  done       <= 1'b1;
               end else begin
                  r_state <= S_SETTLE;
                  r_ch    <= r_ch + 1'b1;
                  r_dwell <= '0;
                  sel     <= r_ch + 1'b1;
               end
            end
            S_DONE: begin
`ifdef MUX_SCAN_CONTINUOUS_EN
               if (start) begin
                  r_state  <= S_SETTLE;
                  r_ch     <= '0;
                  r_dwell  <= '0;
                  r_shadow <= '0;
                  sel      <= '0;
               end else begin
                  r_state <= S_IDLE;
                  sel     <= '0;
                  busy    <= 1'b0;
               end
`else
               r_state <= S_IDLE;
               sel     <= '0;
               busy    <= 1'b0;
`endif
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer with a done-word scoreboard.
// Models the downstream 6:1 mux as mux_in = in[sel].
module tb_mux_scan_sequencer;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       start = 1'b0;
   logic [2:0] sel;
   logic       mux_in;
   logic       busy;
   logic       done;
   logic [5:0] captured;
   logic [3:0] ones_count;
   logic [5:0] in_bits = '0;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int done_cnt = 0;
   logic [9:0] exp_q[$];

   mux_scan_sequencer dut (
      .clock      (clock),
      .resetn     (resetn),
      .start      (start),
      .sel        (sel),
      .mux_in     (mux_in),
      .busy       (busy),
      .done       (done),
      .captured   (captured),
      .ones_count (ones_count)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   always_comb begin
      mux_in = 1'b0;
      if (sel < 3'd6) mux_in = in_bits[sel];
   end

   task automatic check(input string nm,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h",
                  nm, act, exp);
      end
   endtask

   // Scoreboard monitor: every done pulse pops one expected word.
   always @(negedge clock) begin
      if (resetn && done) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            logic [9:0] e;
            e = exp_q.pop_front();
            check("captured", 32'(captured), 32'(e[9:4]));
            check("ones_count", 32'(ones_count), 32'(e[3:0]));
            check("busy_in_done", 32'(busy), 32'd1);
         end
      end
   end

   task automatic start_pulse(output int t0);
      @(posedge clock);
      #1 start = 1'b1;
      @(posedge clock);
      #1 t0 = cyc;
      start = 1'b0;
   endtask

   task automatic wait_done(input string nm, output int dc);
      int n;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!done && n < 100);
      if (!done) check({nm, "_timeout"}, 32'd0, 32'd1);
      dc = cyc;
   endtask

   int t0, dc, d1, d2, dc0;
   int exp_period;

   initial begin
`ifdef MUX_SCAN_CONTINUOUS_EN
      exp_period = 31;
`else
      exp_period = 32;
`endif
      // 1: reset with random inputs
      in_bits = 6'($urandom);
      start = 1'($urandom);
      #3;
      check("rst_sel", 32'(sel), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_captured", 32'(captured), 32'd0);
      check("rst_ones", 32'(ones_count), 32'd0);
      @(negedge clock);
      check("rst_busy_clk", 32'(busy), 32'd0);
      start = 1'b0;
      #2 resetn = 1'b1;

      // 2: basic sweep, sel stepping and latency
      in_bits = 6'b101101;
      exp_q.push_back({6'b101101, 4'd4});
      start_pulse(t0);
      for (int k = 0; k < 30; k++) begin
         @(negedge clock);
         check($sformatf("sel_step%0d", k),
               32'(sel), 32'(k / 5));
         check("busy_sweep", 32'(busy), 32'd1);
      end
      wait_done("s2", dc);
      check("s2_latency", 32'(dc - t0), 32'd30);
      @(negedge clock);
      check("s2_busy_after", 32'(busy), 32'd0);
      check("s2_done_width", 32'(done), 32'd0);

      // 3: start while busy is ignored
      dc0 = done_cnt;
      in_bits = 6'b101101;
      exp_q.push_back({6'b101101, 4'd4});
      start_pulse(t0);
      repeat (9) @(posedge clock);
      #1 start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      wait_done("s3", dc);
      check("s3_latency", 32'(dc - t0), 32'd30);
      @(negedge clock);
      check("s3_busy_fall", 32'(busy), 32'd0);
      repeat (40) @(negedge clock);
      check("s3_one_done", 32'(done_cnt - dc0), 32'd1);
      check("s3_idle", 32'(busy), 32'd0);

      // 4: reset mid-sweep then a clean sweep
      in_bits = 6'b010011;
      start_pulse(t0);
      repeat (14) @(posedge clock);
      @(posedge clock);
      #1 resetn = 1'b0;
      #1;
      check("s4_sel", 32'(sel), 32'd0);
      check("s4_busy", 32'(busy), 32'd0);
      check("s4_done", 32'(done), 32'd0);
      check("s4_captured", 32'(captured), 32'd0);
      check("s4_ones", 32'(ones_count), 32'd0);
      #5 resetn = 1'b1;
      in_bits = 6'b110010;
      exp_q.push_back({6'b110010, 4'd3});
      start_pulse(t0);
      wait_done("s4", dc);
      check("s4_latency", 32'(dc - t0), 32'd30);
      repeat (3) @(negedge clock);

      // 5: start held, done period
      in_bits = 6'b000000;
      exp_q.push_back({6'b000000, 4'd0});
      exp_q.push_back({6'b111111, 4'd6});
      @(posedge clock);
      #1 start = 1'b1;
      wait_done("s5a", d1);
      in_bits = 6'b111111;
      wait_done("s5b", d2);
      start = 1'b0;
      check("s5_period", 32'(d2 - d1), 32'(exp_period));
      repeat (5) @(negedge clock);
      check("s5_idle", 32'(busy), 32'd0);

      // 6: channel 3 input changes before and after its sample
      in_bits = 6'b000000;
      exp_q.push_back({6'b001000, 4'd1});
      start_pulse(t0);
      for (int k = 1; k <= 22; k++) begin
         @(posedge clock);
         #1;
         if (k == 16) in_bits = 6'b001000;
         if (k == 22) in_bits = 6'b000000;
      end
      wait_done("s6", dc);
      check("s6_latency", 32'(dc - t0), 32'd30);
      repeat (3) @(negedge clock);

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
